trigger_merge: RTL and testbench

TRIGGER_MERGE -- requirements
Module: trigger_merge

---
 rtl/trigger_merge_if.sv | 41 ++++
 rtl/trigger_merge.sv | 142 ++++++++++++++
 tb/tb_trigger_merge.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_merge_if.sv
// trigger_merge_if: bundles the trigger inputs, the register-file controls
// and the status outputs of trigger_merge.
//   master : the side that drives the triggers and register controls
//            (register file / testbench)
//   slave  : trigger_merge itself
//   src_trig, reg_src_en   per-source trigger level and enable
//   reg_merge_en           global enable
//   reg_out_width          pulse width in clk cycles (0 means 1)
//   reg_holdoff            dead time after the pulse, in clk cycles
//   reg_cnt_clr            synchronous clear of trig_cnt / drop_cnt
//   trigger, busy          merged pulse output, FSM-not-idle flag
//   trig_src               sources behind the last accepted trigger
//   trig_cnt, drop_cnt     accepted-trigger and rejected-edge counters
interface trigger_merge_if #(
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 32
);
  logic [NUM_SRC-1:0] src_trig;
  logic [NUM_SRC-1:0] reg_src_en;
  logic               reg_merge_en;
  logic [CNT_W-1:0]   reg_out_width;
  logic [CNT_W-1:0]   reg_holdoff;
  logic               reg_cnt_clr;
  logic               trigger;
  logic [NUM_SRC-1:0] trig_src;
  logic [31:0]        trig_cnt;
  logic [31:0]        drop_cnt;
  logic               busy;

  modport master (
    output src_trig, reg_src_en, reg_merge_en, reg_out_width,
           reg_holdoff, reg_cnt_clr,
    input  trigger, trig_src, trig_cnt, drop_cnt, busy
  );

  modport slave (
    input  src_trig, reg_src_en, reg_merge_en, reg_out_width,
           reg_holdoff, reg_cnt_clr,
    output trigger, trig_src, trig_cnt, drop_cnt, busy
  );
endinterface

// File: rtl/trigger_merge.sv
// trigger_merge: merges NUM_SRC trigger levels into one stretched pulse.
// A rising edge on any enabled source starts a pulse of reg_out_width cycles,
// followed by reg_holdoff dead cycles. Edges arriving while busy are counted
// in drop_cnt and discarded.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : trigger_merge_if.slave (triggers, controls, status)
module trigger_merge #(
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  trigger_merge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               trigger_reg, trigger_next;
  logic [NUM_SRC-1:0] trig_src_reg, trig_src_next;
  logic [NUM_SRC-1:0] qual_d_reg;
  logic [NUM_SRC-1:0] qual;
  logic [NUM_SRC-1:0] rise;
  logic [31:0]        trig_cnt_reg;
  logic [31:0]        drop_cnt_reg;
  logic               accept;
  logic               drop;

  // Per-source qualification and edge detect. qual_d keeps tracking even
  // when merging is disabled, so re-enabling with a level already high does
  // not produce a spurious edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign qual[gi] = bus.src_trig[gi] & bus.reg_src_en[gi];
      assign rise[gi] = qual[gi] & ~qual_d_reg[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) qual_d_reg[gi] <= 1'b0;
        else     qual_d_reg[gi] <= qual[gi];
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    trigger_next  = trigger_reg;
    trig_src_next = trig_src_reg;
    accept        = 1'b0;
    drop          = 1'b0;

    if (!bus.reg_merge_en) begin
      // Global disable aborts whatever phase is running.
      state_next   = IDLE;
      trigger_next = 1'b0;
      cnt_next     = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|rise) begin
            state_next    = PULSE;
            trigger_next  = 1'b1;
            trig_src_next = rise;
            // Width 0 behaves as a single-cycle pulse.
            cnt_next      = (bus.reg_out_width == '0) ? CNT_W'(1) : bus.reg_out_width;
            accept        = 1'b1;
          end
        end
        PULSE: begin
          drop = |rise;
          // cnt_reg holds the cycles remaining including the current one.
          if (cnt_reg <= CNT_W'(1)) begin
            trigger_next = 1'b0;
            if (bus.reg_holdoff != '0) begin
              state_next = HOLDOFF;
              cnt_next   = bus.reg_holdoff;
            end else begin
              state_next = IDLE;
              cnt_next   = '0;
            end
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        HOLDOFF: begin
          drop = |rise;
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_next   = IDLE;
          trigger_next = 1'b0;
          cnt_next     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      trigger_reg  <= 1'b0;
      trig_src_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      trigger_reg  <= trigger_next;
      trig_src_reg <= trig_src_next;
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else if (bus.reg_cnt_clr) begin
      trig_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (accept && (trig_cnt_reg != 32'hFFFF_FFFF))
        trig_cnt_reg <= trig_cnt_reg + 32'd1;
      if (drop && (drop_cnt_reg != 32'hFFFF_FFFF))
        drop_cnt_reg <= drop_cnt_reg + 32'd1;
    end
  end

  assign bus.trigger  = trigger_reg;
  assign bus.trig_src = trig_src_reg;
  assign bus.trig_cnt = trig_cnt_reg;
  assign bus.drop_cnt = drop_cnt_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_trigger_merge.sv
// tb_trigger_merge: directed bench for trigger_merge. Expected trigger
// source masks and counts are queued when a trigger edge is driven and
// popped when the merged pulse appears.
module tb_trigger_merge;

  localparam int NUM_SRC = 3;
  localparam int CNT_W   = 32;

  typedef struct {
    logic [NUM_SRC-1:0] src;
    logic [31:0]        cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tc       = 0;
  exp_t sb[$];

  trigger_merge_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

  trigger_merge #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NUM_SRC-1:0] src, input logic [31:0] cnt);
    exp_t e;
    e.src = src;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Step until trigger rises (bounded), then check it against the queue head.
  task automatic wait_rise(input string tag);
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.trigger) break;
    end
    chk({tag, "_seen"}, 32'(bus.trigger), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_src"}, 32'(bus.trig_src), 32'(e.src));
      chk({tag, "_cnt"}, bus.trig_cnt, e.cnt);
    end
  endtask

  // Called while trigger is high in its first cycle.
  task automatic measure_width(input string tag, input int expw);
    int w;
    w = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!bus.trigger) break;
      w++;
    end
    chk({tag, "_width"}, 32'(w), 32'(expw));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      step();
    end
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.src_trig      = '0;
    bus.reg_src_en    = 3'b111;
    bus.reg_merge_en  = 1'b1;
    bus.reg_out_width = 32'd4;
    bus.reg_holdoff   = 32'd2;
    bus.reg_cnt_clr   = 1'b0;

    // Reset state
    #12;
    chk("rst_trigger", 32'(bus.trigger), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_src", 32'(bus.trig_src), 32'd0);
    chk("rst_tcnt", bus.trig_cnt, 32'd0);
    chk("rst_dcnt", bus.drop_cnt, 32'd0);
    rst = 1'b0;
    step();
    step();

    // Single edge on src[1], W=4 H=2: trigger 4 cycles, busy 6 cycles
    bus.src_trig = 3'b010;
    tc++;
    push_exp(3'b010, 32'(tc));
    wait_rise("single");
    bus.src_trig = '0;
    for (int c = 2; c <= 7; c++) begin
      step();
      chk($sformatf("single_trig_c%0d", c), 32'(bus.trigger), 32'(c <= 4));
      chk($sformatf("single_busy_c%0d", c), 32'(bus.busy), 32'(c <= 6));
    end

    // Counter clear
    bus.reg_cnt_clr = 1'b1;
    step();
    bus.reg_cnt_clr = 1'b0;
    tc = 0;
    chk("clr_tcnt", bus.trig_cnt, 32'd0);
    chk("clr_src_kept", 32'(bus.trig_src), 32'b010);

    // Drop scenario: one-cycle pulses at r0 (accept), r2 (in PULSE),
    // r5 (in HOLDOFF), r7 (accept, minimum spacing 4+2+1)
    bus.src_trig = 3'b001;
    tc++;
    push_exp(3'b001, 32'(tc));
    wait_rise("drop_a");                           // r1
    bus.src_trig = 3'b000; step();                 // r2
    bus.src_trig = 3'b001; step();                 // r3
    bus.src_trig = 3'b000; step();                 // r4
    step();                                        // r5
    chk("drop_holdoff_busy", 32'(bus.busy), 32'd1);
    chk("drop_holdoff_trig", 32'(bus.trigger), 32'd0);
    bus.src_trig = 3'b001; step();                 // r6
    bus.src_trig = 3'b000; step();                 // r7
    chk("drop_idle_r7", 32'(bus.busy), 32'd0);
    bus.src_trig = 3'b001;
    tc++;
    push_exp(3'b001, 32'(tc));
    wait_rise("drop_b");
    chk("drop_cnt2", bus.drop_cnt, 32'd2);
    bus.src_trig = 3'b000;
    measure_width("drop_b", 4);
    wait_idle("drop_b");

    // Simultaneous edges on src[0] and src[2]
    bus.src_trig = 3'b101;
    tc++;
    push_exp(3'b101, 32'(tc));
    wait_rise("simul");
    bus.src_trig = 3'b000;
    measure_width("simul", 4);
    wait_idle("simul");
    chk("simul_dcnt", bus.drop_cnt, 32'd2);

    // Width 0, holdoff 0: src[0] toggles every 2 cycles, each rise accepted
    bus.reg_out_width = 32'd0;
    bus.reg_holdoff   = 32'd0;
    bus.reg_cnt_clr   = 1'b1;
    step();
    bus.reg_cnt_clr   = 1'b0;
    tc = 0;
    for (int r = 0; r < 16; r++) begin
      bus.src_trig = {2'b00, ((r / 2) % 2) == 0};
      if ((r % 4) == 0) begin
        tc++;
        push_exp(3'b001, 32'(tc));
      end
      step();
      chk($sformatf("w0_trig_r%0d", r), 32'(bus.trigger), 32'((r % 4) == 0));
      chk($sformatf("w0_busy_r%0d", r), 32'(bus.busy), 32'((r % 4) == 0));
      if (bus.trigger && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("w0_cnt_r%0d", r), bus.trig_cnt, e.cnt);
      end
    end
    bus.src_trig = 3'b000;
    step();
    chk("w0_dcnt", bus.drop_cnt, 32'd0);
    chk("w0_sb_empty", 32'(sb.size()), 32'd0);

    // Width changed mid-pulse only takes effect on the next load
    bus.reg_out_width = 32'd2;
    bus.src_trig = 3'b001;
    tc++;
    push_exp(3'b001, 32'(tc));
    wait_rise("midw");
    bus.reg_out_width = 32'd7;
    bus.src_trig = 3'b000;
    measure_width("midw", 2);
    wait_idle("midw");

    // Abort: merge disabled in the 2nd pulse cycle
    bus.reg_out_width = 32'd4;
    bus.reg_holdoff   = 32'd2;
    bus.src_trig = 3'b010;
    tc++;
    push_exp(3'b010, 32'(tc));
    wait_rise("abort");                            // pulse cycle 1
    bus.src_trig = 3'b000;
    step();                                        // pulse cycle 2
    bus.reg_merge_en = 1'b0;
    step();
    chk("abort_trig", 32'(bus.trigger), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    bus.src_trig = 3'b001;                         // edge while disabled
    step();
    chk("dis_trig", 32'(bus.trigger), 32'd0);
    bus.reg_merge_en = 1'b1;                       // level already high: no edge
    step();
    chk("reen_trig", 32'(bus.trigger), 32'd0);
    chk("reen_tcnt", bus.trig_cnt, 32'(tc));
    bus.src_trig = 3'b000;
    step();

    // Clear together with an accepted trigger: clear wins
    bus.src_trig = 3'b100;
    bus.reg_cnt_clr = 1'b1;
    tc = 0;
    push_exp(3'b100, 32'(tc));
    wait_rise("clracc");
    bus.reg_cnt_clr = 1'b0;
    bus.src_trig = 3'b000;
    wait_idle("clracc");

    // Saturation of drop_cnt
    bus.src_trig = 3'b001;
    tc++;
    push_exp(3'b001, 32'(tc));
    wait_rise("sat");                              // r1
    force dut.drop_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.drop_cnt_reg;
    bus.src_trig = 3'b000; step();                 // r2
    chk("sat_preload", bus.drop_cnt, 32'hFFFF_FFFE);
    bus.src_trig = 3'b001; step();                 // r3
    chk("sat_max", bus.drop_cnt, 32'hFFFF_FFFF);
    bus.src_trig = 3'b000; step();                 // r4
    bus.src_trig = 3'b001; step();                 // r5
    chk("sat_hold", bus.drop_cnt, 32'hFFFF_FFFF);
    bus.src_trig = 3'b000;
    wait_idle("sat");

    // Reset mid-pulse drops everything without a clock edge
    bus.src_trig = 3'b010;
    tc++;
    push_exp(3'b010, 32'(tc));
    wait_rise("arst");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_trig", 32'(bus.trigger), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_src", 32'(bus.trig_src), 32'd0);
    chk("arst_tcnt", bus.trig_cnt, 32'd0);
    chk("arst_dcnt", bus.drop_cnt, 32'd0);

    // Release with an enabled source already high triggers
    bus.src_trig = 3'b001;
    #3;
    rst = 1'b0;
    tc = 1;
    push_exp(3'b001, 32'(tc));
    wait_rise("relhigh");
    bus.src_trig = 3'b000;
    measure_width("relhigh", 4);
    wait_idle("relhigh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
